// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: it queues host writes and hands bytes
// one at a time over the Tx_Byte/Tx_Ready handshake, pacing on the transmitter's status.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_Wr_En,
  input  logic [7:0]               i_Wr_Byte,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Overflow,
  output logic [7:0]               o_Tx_Byte,
  output logic                     o_Tx_Ready,
  input  logic                     i_Tx_Active,
  input  logic                     i_Tx_Done
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  logic [7:0]             mem_reg [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_reg;
  logic [ADDR_W-1:0]      rd_ptr_reg;
  logic [ADDR_W:0]        count_reg;
  logic [ADDR_W:0]        count_next;
  state_t                 state_reg;
  logic [7:0]             tx_byte_reg;
  logic                   tx_ready_reg;
  logic                   overflow_reg;
  logic [SYNC_STAGES-1:0] act_sync_reg;
  logic [SYNC_STAGES-1:0] done_sync_reg;
  logic                   done_d_reg;

  logic act_s;
  logic done_s;
  logic done_rise;
  logic push_ok;
  logic pop_go;

  assign o_Full     = (count_reg == CNT_FULL);
  assign o_Empty    = (count_reg == '0);
  assign o_Count    = count_reg;
  assign o_Overflow = overflow_reg;
  assign o_Tx_Byte  = tx_byte_reg;
  assign o_Tx_Ready = tx_ready_reg;

  assign act_s     = act_sync_reg[SYNC_STAGES-1];
  assign done_s    = done_sync_reg[SYNC_STAGES-1];
  assign done_rise = done_s && !done_d_reg;

  // Flags are taken from the start-of-cycle count, so a full FIFO drops a push
  // even when a pop frees a slot in the same cycle.
  assign push_ok = i_Wr_En && !o_Full;
  assign pop_go  = (state_reg == IDLE) && !o_Empty && !act_s;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_go})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Transmitter status lives in the baud-tick domain; resynchronise before use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_sync_reg  <= '0;
      done_sync_reg <= '0;
      done_d_reg    <= 1'b0;
    end else begin
      act_sync_reg  <= {act_sync_reg[SYNC_STAGES-2:0], i_Tx_Active};
      done_sync_reg <= {done_sync_reg[SYNC_STAGES-2:0], i_Tx_Done};
      done_d_reg    <= done_s;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      state_reg    <= IDLE;
      tx_byte_reg  <= 8'h00;
      tx_ready_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (i_Wr_En && o_Full) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (pop_go) begin
            tx_byte_reg  <= mem_reg[rd_ptr_reg];
            rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
            tx_ready_reg <= 1'b1;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          // A frame short enough to slip past the Active sampler still ends here.
          if (act_s) begin
            tx_ready_reg <= 1'b0;
            state_reg    <= WAIT;
          end else if (done_rise) begin
            tx_ready_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        WAIT: begin
          if (done_rise) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          tx_ready_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a simple transmitter model consumes bytes and checks
// them against a queue of accepted pushes, plus fixed-timing checks on flags.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] tx_byte;
  logic       tx_ready;

  int         n_checks = 0;
  int         n_pass = 0;
  int         pushed = 0;
  int         served = 0;
  int         viol = 0;
  logic [7:0] sb[$];
  logic [2:0] act_d;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i_Wr_En(wr_en), .i_Wr_Byte(wr_byte),
    .o_Full(full), .o_Empty(empty), .o_Count(count), .o_Overflow(overflow),
    .o_Tx_Byte(tx_byte), .o_Tx_Ready(tx_ready),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
  );

  // Active as the FSM has had time to act on it: two sync flops plus one FSM edge.
  always @(posedge clk or posedge reset) begin
    if (reset) act_d <= 3'b000;
    else       act_d <= {act_d[1:0], tx_active};
  end

  always @(negedge clk) begin
    if (!reset && tx_ready && act_d[2]) viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete(); pushed = 0; served = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_en = 1'b1; wr_byte = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (accept) begin
      sb.push_back(b);
      pushed++;
    end
    $display("push  byte=%02h expect_accept=%0d", b, accept);
  endtask

  // Transmitter model: Active rises 3 cycles after Ready, Done pulses 10 cycles later.
  task automatic tx_serve(input int n);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      logic [7:0] exp_b;
      while (!tx_ready && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      n_checks++;
      if (!tx_ready) begin
        $display("FAIL tx_ready_timeout got=0 exp=1 after %0d cycles", waited);
        return;
      end
      n_pass++;
      served++;
      exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      n_checks++;
      if (tx_byte !== exp_b) $display("FAIL tx_byte got=%02h exp=%02h", tx_byte, exp_b);
      else begin n_pass++; $display("send  byte=%02h ok", tx_byte); end
      n_checks++;
      if (int'(count) !== pushed - served)
        $display("FAIL count_track got=%0d exp=%0d", count, pushed - served);
      else n_pass++;
      repeat (3) @(negedge clk);
      tx_active = 1'b1;
      repeat (10) @(negedge clk);
      tx_done = 1'b1; tx_active = 1'b0;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b0) $display("FAIL rst_ready got=%0b exp=0", tx_ready); else n_pass++;
    n_checks++; if (tx_byte !== 8'h00) $display("FAIL rst_byte got=%02h exp=00", tx_byte); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL rst_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rst_flags got=e%0b f%0b o%0b exp=e1 f0 o0", empty, full, overflow);
    else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (tx_ready !== 1'b0) $display("FAIL idle_ready got=%0b exp=0", tx_ready); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    push_byte(8'hA5, 1'b1);
    @(negedge clk);
    n_checks++; if (empty !== 1'b0 || count !== 5'd1)
      $display("FAIL single_after_push got=e%0b c%0d exp=e0 c1", empty, count);
    else n_pass++;
    n_checks++; if (tx_ready !== 1'b0) $display("FAIL single_early_ready got=%0b exp=0", tx_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1 || tx_byte !== 8'hA5)
      $display("FAIL single_pop got=r%0b b%02h exp=r1 bA5", tx_ready, tx_byte);
    else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL single_count got=%0d exp=0", count); else n_pass++;
    tx_serve(1);
    repeat (5) @(negedge clk);
    n_checks++; if (tx_byte !== 8'hA5) $display("FAIL single_hold got=%02h exp=A5", tx_byte); else n_pass++;
    $display("test_single done");
  endtask

  task automatic test_full_overflow();
    apply_reset();
    tx_active = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 16; i++) push_byte(8'(i), 1'b1);
    @(negedge clk);
    n_checks++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0)
      $display("FAIL full_flags got=f%0b c%0d o%0b exp=f1 c16 o0", full, count, overflow);
    else n_pass++;
    n_checks++; if (tx_ready !== 1'b0) $display("FAIL full_ready got=%0b exp=0", tx_ready); else n_pass++;
    push_byte(8'h11, 1'b0);
    @(negedge clk);
    n_checks++; if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1)
      $display("FAIL overflow got=o%0b c%0d f%0b exp=o1 c16 f1", overflow, count, full);
    else n_pass++;
    $display("test_full_overflow done");
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    tx_active = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 16; i++) push_byte(8'(i), 1'b1);
    @(negedge clk);
    tx_active = 1'b0;
    @(negedge clk);
    push_byte(8'h77, 1'b0);
    @(negedge clk);
    n_checks++; if (count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0)
      $display("FAIL pushpop_full got=c%0d o%0b f%0b exp=c15 o1 f0", count, overflow, full);
    else n_pass++;
    n_checks++; if (tx_ready !== 1'b1 || tx_byte !== 8'h01)
      $display("FAIL pushpop_pop got=r%0b b%02h exp=r1 b01", tx_ready, tx_byte);
    else n_pass++;
    tx_serve(16);
    repeat (20) @(negedge clk);
    n_checks++; if (empty !== 1'b1 || sb.size() != 0 || tx_ready !== 1'b0)
      $display("FAIL pushpop_drain got=e%0b q%0d r%0b exp=e1 q0 r0", empty, sb.size(), tx_ready);
    else n_pass++;
    $display("test_full_push_pop done");
  endtask

  task automatic test_order();
    apply_reset();
    fork
      begin
        push_byte(8'h03, 1'b1);
        push_byte(8'h07, 1'b1);
        push_byte(8'h09, 1'b1);
      end
      tx_serve(3);
    join
    repeat (20) @(negedge clk);
    n_checks++; if (sb.size() != 0 || empty !== 1'b1)
      $display("FAIL order_drain got=q%0d e%0b exp=q0 e1", sb.size(), empty);
    else n_pass++;
    n_checks++; if (viol != 0) $display("FAIL ready_vs_active got=%0d exp=0", viol); else n_pass++;
    $display("test_order done");
  endtask

  task automatic test_stream();
    apply_reset();
    tx_active = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), 1'b1);
    @(negedge clk);
    n_checks++; if (count !== 5'd8) $display("FAIL stream_half got=%0d exp=8", count); else n_pass++;
    tx_active = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) push_byte(8'h28 + 8'(i), 1'b1);
        repeat (200) @(negedge clk);
        for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i), 1'b1);
      end
      tx_serve(24);
    join
    repeat (20) @(negedge clk);
    n_checks++; if (count !== 5'd0 || empty !== 1'b1 || sb.size() != 0)
      $display("FAIL stream_drain got=c%0d e%0b q%0d exp=c0 e1 q0", count, empty, sb.size());
    else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL stream_overflow got=%0b exp=0", overflow); else n_pass++;
    $display("test_stream done");
  endtask

  task automatic test_reset_in_wait();
    int waited = 0;
    bit seen_ready = 1'b0;
    apply_reset();
    tx_active = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) push_byte(8'h40 + 8'(i), 1'b1);
    @(negedge clk);
    tx_active = 1'b0;
    while (!tx_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (tx_ready !== 1'b1 || tx_byte !== 8'h40)
      $display("FAIL rw_first got=r%0b b%02h exp=r1 b40", tx_ready, tx_byte);
    else n_pass++;
    tx_active = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (count !== 5'd5 || tx_ready !== 1'b0)
      $display("FAIL rw_wait got=c%0d r%0b exp=c5 r0", count, tx_ready);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (tx_ready !== 1'b0 || tx_byte !== 8'h00 || count !== 5'd0 ||
                    empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rw_async got=r%0b b%02h c%0d e%0b f%0b o%0b exp=r0 b00 c0 e1 f0 o0",
               tx_ready, tx_byte, count, empty, full, overflow);
    else n_pass++;
    tx_active = 1'b0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete(); pushed = 0; served = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_ready) seen_ready = 1'b1;
    end
    n_checks++; if (seen_ready || empty !== 1'b1)
      $display("FAIL rw_after got=r%0b e%0b exp=r0 e1", seen_ready, empty);
    else n_pass++;
    push_byte(8'h5A, 1'b1);
    tx_serve(1);
    repeat (20) @(negedge clk);
    n_checks++; if (sb.size() != 0 || empty !== 1'b1)
      $display("FAIL rw_drain got=q%0d e%0b exp=q0 e1", sb.size(), empty);
    else n_pass++;
    $display("test_reset_in_wait done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_full_push_pop();
    test_order();
    test_stream();
    test_reset_in_wait();
    n_checks++; if (viol != 0) $display("FAIL ready_vs_active_total got=%0d exp=0", viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
